// File: rtl/calc_display_pkg.sv
// ============================================================================
// Module  : calc_disp_pkg
// Purpose : Shared types, status encodings and segment codes for calc_display.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package calc_disp_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [1:0] status_t;

    localparam status_t ST_ERR   = 2'b00;
    localparam status_t ST_BUSY  = 2'b01;
    localparam status_t ST_READY = 2'b10;

    // Segment codes are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_O     = 7'h23;

endpackage

`default_nettype wire

// File: rtl/calc_display_if.sv
// ============================================================================
// Module  : calc_display_if
// Purpose : Serial digit stream from the calculator core to the display.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface calc_display_if;
    import calc_disp_pkg::*;

    status_t    status_i;
    digit_t     data_i;
    logic [3:0] pos_i;

    modport master (output status_i, output data_i, output pos_i);
    modport slave  (input  status_i, input  data_i, input  pos_i);

endinterface

`default_nettype wire

// File: rtl/calc_display_seg7_decode.sv
// ============================================================================
// Module  : seg7_decode
// Purpose : Combinational digit-to-segment decoder with blanking override.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import calc_disp_pkg::*;
(
    input  digit_t     value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (value)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/calc_display.sv
// ============================================================================
// Module  : calc_display
// Purpose : Frame capture/commit of the core's digit stream and 8-digit scan.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module calc_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1,
    parameter int NDIG        = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    calc_display_if.slave        core,
    output logic [7:0]           an,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic                 frame_done
);

    localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    typedef logic [TICK_W-1:0] tick_t;
    localparam tick_t TICK_LAST = tick_t'(REFRESH_DIV - 1);

    logic [NDIG-1:0][3:0] shadow_q, shadow_d;
    logic [NDIG-1:0][3:0] disp_q,   disp_d;
    logic [2:0]           scan_q,   scan_d;
    tick_t                tick_q,   tick_d;
    status_t              st_q,     st_d;
    logic                 err_q,    err_d;
    logic [7:0]           an_q,     an_d;
    logic [6:0]           seg_q,    seg_d;
    logic                 frame_done_q, frame_done_d;

    logic                 commit;
    logic                 wrap;
    logic [NDIG-1:0]      tail_zero;
    logic                 lz_blank;
    logic [6:0]           dec_seg;
    logic [6:0]           err_seg;
    logic [7:0]           an_next;

    // tail_zero[i]: this digit and every more-significant digit are zero
    for (genvar i = 0; i < NDIG; i++) begin : g_lz
        assign tail_zero[i] = (disp_q[NDIG-1:i] == '0);
    end

    assign lz_blank = BLANK_LZ && (scan_q != 3'd0) && tail_zero[scan_q];

    seg7_decode u_decode (
        .value (disp_q[scan_q]),
        .blank (lz_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        err_seg = SEG_BLANK;
        case (scan_q)
            3'd3:    err_seg = SEG_E;
            3'd2:    err_seg = SEG_R;
            3'd1:    err_seg = SEG_R;
            3'd0:    err_seg = SEG_O;
            default: err_seg = SEG_BLANK;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        if (core.status_i == ST_BUSY && !core.pos_i[3]) begin
            shadow_d[core.pos_i[2:0]] = core.data_i;
        end

        // A would-be commit and an error are mutually exclusive on status_i,
        // so gating on err_q alone keeps the error sticky over later frames.
        commit       = (st_q == ST_BUSY) && (core.status_i == ST_READY) && !err_q;
        disp_d       = commit ? shadow_q : disp_q;
        frame_done_d = commit;
        st_d         = core.status_i;
        err_d        = err_q | (core.status_i == ST_ERR);

        wrap   = (tick_q == TICK_LAST);
        tick_d = wrap ? '0 : tick_q + tick_t'(1);
        scan_d = wrap ? scan_q + 3'd1 : scan_q;

        an_next         = 8'hFF;
        an_next[scan_q] = 1'b0;
        an_d  = wrap ? an_next : an_q;
        seg_d = wrap ? (err_q ? err_seg : dec_seg) : seg_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q     <= '0;
            disp_q       <= '0;
            scan_q       <= '0;
            tick_q       <= '0;
            st_q         <= ST_ERR;
            err_q        <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            scan_q       <= scan_d;
            tick_q       <= tick_d;
            st_q         <= st_d;
            err_q        <= err_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire
